// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encodings, controller
// states and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes 12..15 are reserved and reported as illegal.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_SRA);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// full 2*WIDTH product, single-cycle done pulse when the product is final.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                // Last bit consumed on this edge; acc_q is final afterwards.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops registered on acceptance, MUL handed to
// the iterative multiplier; result and flags held in DONE until consumed.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q, zero_q, ovf_q, illegal_q;

    logic               in_fire;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic               sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_w;
    logic               add_ovf;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf, alu_ill;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign in_fire   = in_valid && in_ready;
    assign mul_start = in_fire && (command == OP_MUL);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // SUB and SLT share the adder as a + ~b + 1.
    assign sub_op  = (command == OP_SUB) || (command == OP_SLT);
    assign b_eff   = sub_op ? ~b : b;
    assign sum_w   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    assign shamt   = b[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = !op_is_legal(command);
        case (command)
            OP_ADD, OP_SUB: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_SLT: begin
                // Sign of the difference corrected by overflow gives a true signed compare.
                alu_res   = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ add_ovf};
                alu_carry = sum_w[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_XOR:  alu_res = a ^ b;
            OP_AND:  alu_res = a & b;
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_OR:   alu_res = a | b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) state_d = (command == OP_MUL) ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (in_fire)        state_d = (command == OP_MUL) ? ST_BUSY : ST_DONE;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire && (command != OP_MUL)) begin
                result_q  <= alu_res;
                carry_q   <= alu_carry;
                zero_q    <= (alu_res == '0);
                ovf_q     <= alu_ovf;
                illegal_q <= alu_ill;
            end else if ((state_q == ST_BUSY) && mul_done) begin
                result_q  <= mul_product[WIDTH-1:0];
                carry_q   <= 1'b0;
                zero_q    <= (mul_product[WIDTH-1:0] == '0);
                ovf_q     <= |mul_product[2*WIDTH-1:WIDTH];
                illegal_q <= 1'b0;
            end
        end
    end

    assign result   = result_q;
    assign carryout = carry_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=32 with hand-computed expectations.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  command;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carryout, zero, overflow, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command for exactly one edge (caller controls out_ready).
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        command  = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("op=%0d a=%h b=%h -> result=%h c=%b z=%b o=%b ill=%b vld=%b",
                 op, av, bv, result, carryout, zero, overflow, illegal, out_valid);
    endtask

    // Issue a MUL, pulse in_valid while busy, return edges from acceptance to out_valid.
    task automatic run_mul(input logic [31:0] av, input logic [31:0] bv, input string tag,
                           output int edges);
        issue(4'd8, av, bv);
        edges = 0;
        while (!out_valid && edges < 100) begin
            chk({tag, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);
            in_valid = edges[0];
            command  = 4'd0;
            a        = 32'h1111_1111;
            b        = 32'h2222_2222;
            step();
            edges++;
        end
        in_valid = 1'b0;
        $display("mul a=%h b=%h edges=%0d result=%h o=%b z=%b", av, bv, edges, result, overflow, zero);
    endtask

    int  edges;
    logic seen_valid;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; command = '0;
        step(); step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {59'd0, carryout, zero, overflow, illegal, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        issue(4'd0, 32'h1000_0000, 32'hF000_0000);
        chk("add1_valid", {63'd0, out_valid}, 64'd1);
        chk("add1_result", {32'd0, result}, 64'd0);
        chk("add1_flags", {60'd0, carryout, zero, overflow, illegal}, 64'b1100);
        step();
        chk("add1_consumed", {63'd0, out_valid}, 64'd0);

        issue(4'd0, 32'h8000_0000, 32'h8000_0000);
        chk("add2_result", {32'd0, result}, 64'd0);
        chk("add2_flags", {60'd0, carryout, zero, overflow, illegal}, 64'b1110);
        step();

        issue(4'd1, 32'd5, 32'd7);
        chk("sub_result", {32'd0, result}, 64'hFFFF_FFFE);
        chk("sub_flags", {60'd0, carryout, zero, overflow, illegal}, 64'b0000);
        step();

        issue(4'd3, 32'hFFFF_FFFB, 32'd2);
        chk("slt1_result", {32'd0, result}, 64'd1);
        chk("slt1_flags", {60'd0, carryout, zero, overflow, illegal}, 64'b1000);
        step();
        issue(4'd3, 32'h8000_0000, 32'd1);
        chk("slt2_result", {32'd0, result}, 64'd1);
        chk("slt2_ovf", {63'd0, overflow}, 64'd1);
        step();
        issue(4'd3, 32'd3, 32'd2);
        chk("slt3_result", {32'd0, result}, 64'd0);
        chk("slt3_zero", {63'd0, zero}, 64'd1);
        step();

        issue(4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000);
        chk("nand_result", {32'd0, result}, 64'h0F0F_FFFF);
        step();
        issue(4'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        chk("xor_zero", {62'd0, zero, carryout}, 64'b10);
        step();
        issue(4'd6, 32'h0000_FFFF, 32'h00FF_0000);
        chk("nor_result", {32'd0, result}, 64'hFF00_0000);
        step();
        issue(4'd9, 32'd1, 32'd31);
        chk("sll_result", {32'd0, result}, 64'h8000_0000);
        step();
        issue(4'd10, 32'h8000_0000, 32'h0000_0024);
        chk("srl_result", {32'd0, result}, 64'h0800_0000);
        step();

        run_mul(32'h0001_0000, 32'h0001_0000, "mul1", edges);
        chk("mul1_latency", 64'(edges), 64'd33);
        chk("mul1_result", {32'd0, result}, 64'd0);
        chk("mul1_flags", {60'd0, carryout, zero, overflow, illegal}, 64'b0110);
        step();
        run_mul(32'h0000_FFFF, 32'h0001_0001, "mul2", edges);
        chk("mul2_result", {32'd0, result}, 64'hFFFF_FFFF);
        chk("mul2_ovf", {62'd0, overflow, zero}, 64'd0);
        step();

        out_ready = 1'b0;
        issue(4'd11, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", {32'd0, result}, 64'hF800_0000);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            step();
        end
        out_ready = 1'b1;
        issue(4'd0, 32'd1, 32'd2);
        chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_next_result", {32'd0, result}, 64'd3);
        step();

        issue(4'd8, 32'h0000_FFFF, 32'h0001_0001);
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_outputs", {27'd0, result, carryout, zero, overflow, illegal, out_valid}, 64'd0);
        reset = 1'b0;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_valid |= out_valid;
            step();
        end
        chk("midrst_no_stale", {63'd0, seen_valid}, 64'd0);

        issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("ill_valid", {63'd0, out_valid}, 64'd1);
        chk("ill_result", {32'd0, result}, 64'd0);
        chk("ill_flags", {60'd0, carryout, zero, overflow, illegal}, 64'b0101);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
